// File: rtl/mult_control_unit.sv
// Sequencing FSM for the 8-bit shift-add signed multiplier: clear, ITER add/sub+shift steps, hold in DONE.
// Define MULT_CTRL_SYNC_EN to pass Execute and ClearXA_LoadB through two-flop synchronizers.
module mult_control_unit #(
  parameter int ITER = 8
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Execute,
  input  logic                      ClearXA_LoadB,
  input  logic                      M,
  output logic                      ClearXA,
  output logic                      LoadB,
  output logic                      Add,
  output logic                      Sub,
  output logic                      Shift,
  output logic                      Busy,
  output logic                      Done,
  output logic [$clog2(ITER)-1:0]   Count
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   count_r;
  logic            exec_n_s;
  logic            clr_ld_n_s;

`ifdef MULT_CTRL_SYNC_EN
  logic [1:0] exec_sync_r;
  logic [1:0] clr_ld_sync_r;

  // Two-flop button synchronizers, idling at the released (high) level
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      exec_sync_r   <= 2'b11;
      clr_ld_sync_r <= 2'b11;
    end else begin
      exec_sync_r   <= {exec_sync_r[0], Execute};
      clr_ld_sync_r <= {clr_ld_sync_r[0], ClearXA_LoadB};
    end
  end

  assign exec_n_s   = exec_sync_r[1];
  assign clr_ld_n_s = clr_ld_sync_r[1];
`else
  assign exec_n_s   = Execute;
  assign clr_ld_n_s = ClearXA_LoadB;
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Iteration counter: zeroed in CLEAR, saturates at the last iteration
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_r <= '0;
    end else if (state_r == CLEAR) begin
      count_r <= '0;
    end else if ((state_r == SHIFT) && (count_r != LAST)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Next-state logic; the load button wins over Execute in IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!clr_ld_n_s) begin
          state_nxt_s = IDLE;
        end else if (!exec_n_s) begin
          state_nxt_s = CLEAR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: state_nxt_s = ADD;
      ADD:   state_nxt_s = SHIFT;
      SHIFT: begin
        if (count_r == LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ADD;
        end
      end
      DONE: begin
        if (exec_n_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode; Add/Sub follow M combinationally, the last step subtracts the sign weight
  always_comb begin
    ClearXA = 1'b0;
    LoadB   = 1'b0;
    Add     = 1'b0;
    Sub     = 1'b0;
    Shift   = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!clr_ld_n_s) begin
          ClearXA = 1'b1;
          LoadB   = 1'b1;
        end else begin
          ClearXA = 1'b0;
          LoadB   = 1'b0;
        end
      end
      CLEAR: begin
        ClearXA = 1'b1;
        Busy    = 1'b1;
      end
      ADD: begin
        Busy = 1'b1;
        if (M) begin
          if (count_r == LAST) begin
            Sub = 1'b1;
          end else begin
            Add = 1'b1;
          end
        end else begin
          Add = 1'b0;
          Sub = 1'b0;
        end
      end
      SHIFT: begin
        Shift = 1'b1;
        Busy  = 1'b1;
      end
      DONE:    Done = 1'b1;
      default: Done = 1'b0;
    endcase
  end

  assign Count = count_r;

endmodule

// File: tb/tb_mult_control_unit.sv
// Bench for mult_control_unit: drives a behavioural X/A/B datapath and checks signed products and strobe traces.
// Covers both the raw and the MULT_CTRL_SYNC_EN build via the SYNC_LAT latency constant.
module tb_mult_control_unit;

`ifdef MULT_CTRL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Execute;
  logic       ClearXA_LoadB;
  logic       M;
  logic       ClearXA, LoadB, Add, Sub, Shift, Busy, Done;
  logic [2:0] Count;

  logic [7:0] din = 8'd0;
  logic       dx_x = 1'b0;
  logic [7:0] dx_a = 8'd0;
  logic [7:0] dx_b = 8'd0;
  logic [4:0] cap = 5'd0;

  int total = 0;
  int bad = 0;
  int busy_n, done_n, clr_n, ldb_n, pair_n, shift_n, both_n;
  logic [7:0] add_mask, sub_mask;

  mult_control_unit #(.ITER(8)) dut (
    .Clk(Clk), .Reset(Reset), .Execute(Execute), .ClearXA_LoadB(ClearXA_LoadB), .M(M),
    .ClearXA(ClearXA), .LoadB(LoadB), .Add(Add), .Sub(Sub), .Shift(Shift),
    .Busy(Busy), .Done(Done), .Count(Count)
  );

  always #10 Clk = ~Clk;

  assign M = dx_b[0];

  // Strobes are captured late in the low phase, after the bench has changed its inputs
  always @(negedge Clk) begin
    #8;
    cap = {ClearXA, LoadB, Add, Sub, Shift};
  end

  // Datapath registers X/A/B reacting to the captured strobes
  always @(posedge Clk) begin
    if (Reset) begin
      if (cap[4]) begin
        {dx_x, dx_a} <= 9'd0;
      end else if (cap[2]) begin
        {dx_x, dx_a} <= {dx_a[7], dx_a} + {din[7], din};
      end else if (cap[1]) begin
        {dx_x, dx_a} <= {dx_a[7], dx_a} - {din[7], din};
      end else if (cap[0]) begin
        {dx_x, dx_a, dx_b} <= {dx_x, dx_x, dx_a, dx_b[7:1]};
      end
      if (cap[3]) begin
        dx_b <= din;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_trace();
    busy_n = 0; done_n = 0; clr_n = 0; ldb_n = 0; pair_n = 0; shift_n = 0; both_n = 0;
    add_mask = 8'd0; sub_mask = 8'd0;
  endtask

  task automatic step();
    @(negedge Clk);
    #1;
    if (Busy) busy_n++;
    if (Done) done_n++;
    if (ClearXA && Busy) clr_n++;
    if (LoadB) ldb_n++;
    if (ClearXA && LoadB) pair_n++;
    if (Shift) shift_n++;
    if (Add && Sub) both_n++;
    if (Add) add_mask[Count] = 1'b1;
    if (Sub) sub_mask[Count] = 1'b1;
    #1;
  endtask

  task automatic load_b(input logic [7:0] b_val);
    din = b_val;
    ClearXA_LoadB = 1'b0;
    step();
    ClearXA_LoadB = 1'b1;
    repeat (4) step();
  endtask

  task automatic run_mult(input logic [7:0] a_val, input logic [7:0] b_val, input int hold, input bit poke);
    int lat;
    int t;
    logic signed [15:0] prod;
    prod = $signed(a_val) * $signed(b_val);
    load_b(b_val);
    din = a_val;
    clr_trace();
    Execute = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      lat++;
      if (Busy) break;
    end
    chk("start_lat", lat, 1 + SYNC_LAT);
    t = 0;
    while (!Done && t < 40) begin
      if (poke) ClearXA_LoadB = t[0];
      step();
      t++;
    end
    chk("done_seen", {31'd0, Done}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      if (poke) ClearXA_LoadB = i[0];
      step();
    end
    chk("done_held", done_n, hold + 1);
    chk("busy_len", busy_n, 32'd17);
    Execute = 1'b1;
    ClearXA_LoadB = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      lat++;
      if (!Done) break;
    end
    chk("idle_lat", lat, 1 + SYNC_LAT);
    chk("shift_cnt", shift_n, 32'd8);
    chk("clear_cnt", clr_n, 32'd1);
    chk("loadb_run", ldb_n, 32'd0);
    chk("add_sub_both", both_n, 32'd0);
    chk("add_mask", {24'd0, add_mask}, {24'd0, 1'b0, b_val[6:0]});
    chk("sub_mask", {24'd0, sub_mask}, {24'd0, b_val[7], 7'd0});
    chk("product", {16'd0, dx_a, dx_b}, {16'd0, prod});
  endtask

  initial begin
    bit found;
    Reset = 1'b0;
    Execute = 1'b0;
    ClearXA_LoadB = 1'b1;
    clr_trace();
    repeat (3) step();
    chk("rst_outs", {25'd0, ClearXA, LoadB, Add, Sub, Shift, Busy, Done}, 32'd0);
    chk("rst_count", {29'd0, Count}, 32'd0);

    Execute = 1'b1;
    Reset = 1'b1;
    clr_trace();
    repeat (5) step();
    chk("post_rst_busy", busy_n, 32'd0);
    chk("post_rst_outs", {25'd0, ClearXA, LoadB, Add, Sub, Shift, Busy, Done}, 32'd0);

    // Load button alone, then together with Execute
    clr_trace();
    ClearXA_LoadB = 1'b0;
    repeat (3) step();
    ClearXA_LoadB = 1'b1;
    repeat (6) step();
    chk("btn_pairs", pair_n, 32'd3);
    chk("btn_busy", busy_n, 32'd0);
    clr_trace();
    Execute = 1'b0;
    ClearXA_LoadB = 1'b0;
    repeat (3) step();
    Execute = 1'b1;
    ClearXA_LoadB = 1'b1;
    repeat (6) step();
    chk("both_pairs", pair_n, 32'd3);
    chk("both_busy", busy_n, 32'd0);

    run_mult(8'h9B, 8'hC5, 0, 1'b0);
    run_mult(8'h35, 8'h07, 40, 1'b0);
    run_mult(8'h80, 8'h80, 6, 1'b1);

    // Reset in the ADD step of iteration 4
    load_b(8'h5A);
    din = 8'h77;
    Execute = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (Busy && !Shift && !ClearXA && Count == 3'd4) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_cnt4", {31'd0, found}, 32'd1);
    Reset = 1'b0;
    Execute = 1'b1;
    #1;
    chk("mid_rst_outs", {25'd0, ClearXA, LoadB, Add, Sub, Shift, Busy, Done}, 32'd0);
    chk("mid_rst_count", {29'd0, Count}, 32'd0);
    repeat (2) step();
    Reset = 1'b1;
    repeat (2) step();
    run_mult(8'h77, 8'h5A, 1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      run_mult(8'($urandom), 8'($urandom), int'($urandom_range(0, 5)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_control_unit.md
# mult_control_unit

Control unit for the 8-bit shift-add signed multiplier datapath (X/A/B registers, 9-bit adder/subtractor). Sequences one multiplication per Execute press: clear X and A, run eight add/subtract-then-shift iterations from the multiplier bit M, then hold the result until the button is released. Also services the ClearXA_LoadB button. Sits between the board push-buttons and the register/adder datapath inside the multiplier top level.

## Interface
Parameters:
- ITER, 8, number of add/shift iterations; counter width is $clog2(ITER).

Ports:
- Clk  input  1  system clock, 50 MHz; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low; forces IDLE immediately.
- Execute  input  1  active-low button; low starts a multiply from IDLE.
- ClearXA_LoadB  input  1  active-low button; low in IDLE clears X/A and loads B from Din.
- M  input  1  current LSB of register B (multiplier bit).
- ClearXA  output  1  clear X and A registers.
- LoadB  output  1  load B from Din.
- Add  output  1  load A/X with A + (Din sign-extended).
- Sub  output  1  load A/X with A − (Din sign-extended).
- Shift  output  1  arithmetic right shift of X:A:B.
- Busy  output  1  high from CLEAR through final SHIFT.
- Done  output  1  high in DONE.
- Count  output  $clog2(ITER)  current iteration index.

## Operation
- States: IDLE, CLEAR, ADD, SHIFT, DONE.
- IDLE: if ClearXA_LoadB==0, assert ClearXA and LoadB (combinational, every cycle the button is low), stay IDLE. Else if Execute==0 → CLEAR. ClearXA_LoadB has priority when both low.
- CLEAR: ClearXA=1 for exactly one cycle; Count←0; → ADD.
- ADD: if M==1 and Count<ITER−1, Add=1; if M==1 and Count==ITER−1, Sub=1; if M==0, neither. Add and Sub never both high. → SHIFT.
- SHIFT: Shift=1; if Count==ITER−1 → DONE, else Count←Count+1, → ADD.
- DONE: all datapath strobes low; Done=1; stay until Execute==1, then → IDLE. Prevents repeat runs while button held.
- Buttons other than Execute-release ignored outside IDLE (ClearXA_LoadB ignored while Busy or Done).
- Add/Sub are Mealy on M; all other outputs Moore.
- Count wraps never: saturates at ITER−1 until next CLEAR.

## Timing
- Reset (asynchronous assert, synchronous-safe release): state=IDLE, Count=0, all outputs 0 during and after reset while buttons high.
- Reset mid-operation: returns to IDLE within the same cycle; no further strobes; datapath contents are undefined to the controller.
- Start latency: Execute sampled low at edge k → CLEAR during cycle k+1.
- Run length: CLEAR (1) + ITER×(ADD+SHIFT) = 17 cycles with Busy=1; Done rises on cycle k+18.
- Exactly ITER Shift pulses and one ClearXA pulse per run.
- DONE→IDLE one cycle after Execute sampled high.
- M is sampled only in ADD; datapath must present the post-shift LSB by the next ADD.

## Configuration
- MULT_CTRL_SYNC_EN defined: Execute and ClearXA_LoadB pass through two-flop synchronizers (reset to 1) before the FSM; start latency becomes 3 edges after the pin falls; all other timing unchanged.
- Undefined: buttons used raw; latency as in Timing. Bench must cover both builds.

## Test plan
- Reset held low with Execute=0 → IDLE, all outputs 0, Count=0; release Reset with Execute=1 → stays IDLE.
- ClearXA_LoadB low 3 cycles in IDLE → ClearXA=LoadB=1 for those 3 cycles, no Busy; with Execute also low → no CLEAR entered.
- Execute pulse, M sequence LSB-first 1,0,1,0,0,0,1,1 (B=8'hC5) → Add at Count 0,2,6; Sub at Count 7; 8 Shift pulses; Busy 17 cycles; Done asserted.
- M sequence 1,1,1,0,0,0,0,0 (B=8'h07) → Add at Count 0,1,2; no Sub; Done held while Execute low 40 cycles, IDLE one cycle after release.
- Reset asserted at Count=4 in ADD → all strobes drop immediately, Count=0; next Execute runs a full 17-cycle sequence.
- ClearXA_LoadB low during Busy and during DONE → no LoadB/ClearXA, sequence unaffected.
